// File: rtl/marker_overlay.sv
`default_nettype none
// ============================================================================
// Module   : marker_overlay
// Purpose  : Draws up to N_MARK crosshair (or box) markers over a video
//            stream with a fixed one-clock latency. Marker settings are
//            sampled at the start of each frame and held for that frame.
// Options  : MARKER_OVERLAY_BOX_EN - compiles in box-shaped markers; without
//            it the mode input is ignored and every marker is a crosshair.
// Revision : 1.0 - initial release
// ============================================================================
module marker_overlay #(
    parameter logic [10:0] IMG_W    = 11'd1280,
    parameter logic [10:0] IMG_H    = 11'd720,
    parameter int          N_MARK   = 2,
    parameter int          THICK    = 1,
    parameter int          BOX_HALF = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   de,
    input  logic                   h_sync,
    input  logic                   v_sync,
    input  logic [11*N_MARK-1:0]   x,
    input  logic [11*N_MARK-1:0]   y,
    input  logic [N_MARK-1:0]      mark_en,
    input  logic [24*N_MARK-1:0]   color,
    input  logic                   mode,
    input  logic [23:0]            pixel_in,
    output logic                   de_out,
    output logic                   hsync_out,
    output logic                   vsync_out,
    output logic [23:0]            pixel_out
);

    localparam logic [11:0] c_THICK = 12'(THICK);

    logic [10:0]            r_x_pos;
    logic [10:0]            r_y_pos;
    logic                   r_vs_d;
    logic [11*N_MARK-1:0]   r_xs;
    logic [11*N_MARK-1:0]   r_ys;
    logic [N_MARK-1:0]      r_en;
    logic [24*N_MARK-1:0]   r_color;

    logic                   w_vs_rise;
    logic [N_MARK-1:0]      w_in_range;
    logic [N_MARK-1:0]      w_mark_hit;
    logic                   w_hit;
    logic [23:0]            w_hit_color;

    assign w_vs_rise = v_sync & ~r_vs_d;

`ifdef MARKER_OVERLAY_BOX_EN
    localparam logic [11:0] c_BOX_HALF = 12'(BOX_HALF);
    localparam logic [11:0] c_INNER    = 12'(BOX_HALF - THICK);
    logic                   r_mode;

    // Shape select is a per-frame setting like the marker coordinates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_mode <= 1'b0;
        else if (w_vs_rise)
            r_mode <= mode;
    end
`else
    logic w_unused_mode;
    assign w_unused_mode = mode;
`endif

    // Raster position of the pixel currently on the input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_pos <= 11'd0;
            r_y_pos <= 11'd0;
        end else if (v_sync) begin
            r_x_pos <= 11'd0;
            r_y_pos <= 11'd0;
        end else if (de) begin
            if (r_x_pos == IMG_W - 11'd1) begin
                r_x_pos <= 11'd0;
                if (r_y_pos == IMG_H - 11'd1)
                    r_y_pos <= 11'd0;
                else
                    r_y_pos <= r_y_pos + 11'd1;
            end else begin
                r_x_pos <= r_x_pos + 11'd1;
            end
        end
    end

    // Frame-start shadow capture; off-image markers are disabled at capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_d  <= 1'b0;
            r_xs    <= '0;
            r_ys    <= '0;
            r_en    <= '0;
            r_color <= '0;
        end else begin
            r_vs_d <= v_sync;
            if (w_vs_rise) begin
                r_xs    <= x;
                r_ys    <= y;
                r_en    <= mark_en & w_in_range;
                r_color <= color;
            end
        end
    end

    generate
        for (genvar i = 0; i < N_MARK; i++) begin : g_mark
            logic [11:0] w_dx;
            logic [11:0] w_dy;
            logic [11:0] w_adx;
            logic [11:0] w_ady;
            logic        w_cross;

            assign w_in_range[i] = (x[11*i +: 11] < IMG_W) && (y[11*i +: 11] < IMG_H);

            // Signed 12-bit distance from the shadow position; no edge wrap
            assign w_dx  = {1'b0, r_x_pos} - {1'b0, r_xs[11*i +: 11]};
            assign w_dy  = {1'b0, r_y_pos} - {1'b0, r_ys[11*i +: 11]};
            assign w_adx = w_dx[11] ? (12'd0 - w_dx) : w_dx;
            assign w_ady = w_dy[11] ? (12'd0 - w_dy) : w_dy;

            assign w_cross = (w_adx < c_THICK) || (w_ady < c_THICK);
`ifdef MARKER_OVERLAY_BOX_EN
            logic w_box;
            assign w_box = (w_adx <= c_BOX_HALF) && (w_ady <= c_BOX_HALF) &&
                           ((w_adx > c_INNER) || (w_ady > c_INNER));
            assign w_mark_hit[i] = r_en[i] & (r_mode ? w_box : w_cross);
`else
            assign w_mark_hit[i] = r_en[i] & w_cross;
`endif
        end
    endgenerate

    // Priority select: scanning from the top down lets the lowest index win
    always_comb begin
        w_hit       = 1'b0;
        w_hit_color = 24'd0;
        for (int i = N_MARK - 1; i >= 0; i--) begin
            if (w_mark_hit[i]) begin
                w_hit       = 1'b1;
                w_hit_color = r_color[24*i +: 24];
            end
        end
    end

    // Output stage: one clock of latency for syncs and pixel alike
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_out    <= 1'b0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
            pixel_out <= 24'd0;
        end else begin
            de_out    <= de;
            hsync_out <= h_sync;
            vsync_out <= v_sync;
            pixel_out <= (de && w_hit) ? w_hit_color : pixel_in;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_marker_overlay.sv
`default_nettype none
// ============================================================================
// Module   : tb_marker_overlay
// Purpose  : Scoreboard bench for marker_overlay. A driver issues frames and
//            pushes the expected output of each cycle, computed from a
//            frame-level reference model; a monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_marker_overlay;

    localparam int W  = 16;
    localparam int H  = 8;
    localparam int NM = 2;
    localparam int TH = 1;
    localparam int BH = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         de, h_sync, v_sync, mode;
    logic [21:0]  x, y;
    logic [1:0]   mark_en;
    logic [47:0]  color;
    logic [23:0]  pixel_in;
    logic         de_out, hsync_out, vsync_out;
    logic [23:0]  pixel_out;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic [23:0] px;
    } exp_t;

    exp_t q[$];

    // Reference model state: pixel index within the frame plus shadows
    int          mcnt;
    bit          prev_vs;
    bit          m_en  [NM];
    int          m_x   [NM];
    int          m_y   [NM];
    logic [23:0] m_col [NM];
    bit          m_box;

    marker_overlay #(
        .IMG_W(11'd16), .IMG_H(11'd8), .N_MARK(NM), .THICK(TH), .BOX_HALF(BH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .de(de), .h_sync(h_sync), .v_sync(v_sync),
        .x(x), .y(y), .mark_en(mark_en), .color(color), .mode(mode),
        .pixel_in(pixel_in), .de_out(de_out), .hsync_out(hsync_out),
        .vsync_out(vsync_out), .pixel_out(pixel_out)
    );

    always #5 clk = ~clk;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Colour the model expects at raster pixel (px, py), or pin if none
    function automatic logic [23:0] model_pixel(input int px, input int py,
                                                input logic [23:0] pin);
        for (int i = 0; i < NM; i++) begin
            int  adx, ady;
            bit  hit;
            adx = iabs(px - m_x[i]);
            ady = iabs(py - m_y[i]);
            if (m_box)
                hit = (adx <= BH) && (ady <= BH) && ((adx > BH - TH) || (ady > BH - TH));
            else
                hit = (adx < TH) || (ady < TH);
            if (m_en[i] && hit)
                return m_col[i];
        end
        return pin;
    endfunction

    task automatic set_marker(input int i, input int mx, input int my,
                              input bit en, input logic [23:0] c);
        x[11*i +: 11]     = 11'(mx);
        y[11*i +: 11]     = 11'(my);
        mark_en[i]        = en;
        color[24*i +: 24] = c;
    endtask

    // One pixel clock: drive inputs, predict the output, advance the model
    task automatic cycle(input logic d, input logic h, input logic v, input logic r);
        exp_t        e;
        logic [23:0] pin;
        @(negedge clk);
        pin      = 24'($urandom);
        rst_n    = r;
        de       = d;
        h_sync   = h;
        v_sync   = v;
        pixel_in = pin;
        if (!r) begin
            e = '0;
            #1;
            checks++;
            if ({de_out, hsync_out, vsync_out, pixel_out} !== 27'd0) begin
                errors++;
                $display("FAIL reset_async: outputs %b%b%b %h, required all zero",
                         de_out, hsync_out, vsync_out, pixel_out);
            end
        end else begin
            e.de = d;
            e.hs = h;
            e.vs = v;
            e.px = d ? model_pixel(mcnt % W, mcnt / W, pin) : pin;
        end
        q.push_back(e);
        if (!r) begin
            mcnt    = 0;
            prev_vs = 1'b0;
            m_box   = 1'b0;
            for (int i = 0; i < NM; i++) begin
                m_en[i] = 1'b0; m_x[i] = 0; m_y[i] = 0; m_col[i] = '0;
            end
        end else begin
            if (v) begin
                mcnt = 0;
                if (!prev_vs) begin
                    for (int i = 0; i < NM; i++) begin
                        m_x[i]   = int'(x[11*i +: 11]);
                        m_y[i]   = int'(y[11*i +: 11]);
                        m_col[i] = color[24*i +: 24];
                        m_en[i]  = mark_en[i] && (m_x[i] < W) && (m_y[i] < H);
                    end
`ifdef MARKER_OVERLAY_BOX_EN
                    m_box = mode;
`else
                    m_box = 1'b0;
`endif
                end
            end else if (d) begin
                mcnt = (mcnt + 1) % (W * H);
            end
            prev_vs = v;
        end
    endtask

    // Full frame; optional mid-frame reset, x0 change and de gaps
    task automatic run_frame(input int reset_row, input int change_row,
                             input int new_x0, input bit gaps);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        for (int row = 0; row < H; row++) begin
            if (row == change_row)
                x[10:0] = 11'(new_x0);
            if (row == reset_row) begin
                for (int k = 0; k < 3; k++)
                    cycle(1'b0, 1'b0, 1'b0, 1'b0);
            end
            for (int col = 0; col < W; col++) begin
                if (gaps && ($urandom_range(0, 7) == 0))
                    cycle(1'b0, 1'b0, 1'b0, 1'b1);
                cycle(1'b1, 1'b0, 1'b0, 1'b1);
            end
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
            cycle(1'b0, 1'b1, 1'b0, 1'b1);
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    // Monitor: one expected entry per clock, compared after the edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if ({de_out, hsync_out, vsync_out} !== {e.de, e.hs, e.vs}) begin
                errors++;
                $display("FAIL syncs @%0t: de/hs/vs got %b%b%b, required %b%b%b",
                         $time, de_out, hsync_out, vsync_out, e.de, e.hs, e.vs);
            end
            checks++;
            if (pixel_out !== e.px) begin
                errors++;
                $display("FAIL pixel @%0t: got %h, required %h", $time, pixel_out, e.px);
            end
        end
    end

    initial begin
        rst_n = 1'b0; de = 1'b0; h_sync = 1'b0; v_sync = 1'b0; mode = 1'b0;
        x = '0; y = '0; mark_en = '0; color = '0; pixel_in = '0;
        mcnt = 0; prev_vs = 1'b0; m_box = 1'b0;
        for (int i = 0; i < NM; i++) begin
            m_en[i] = 1'b0; m_x[i] = 0; m_y[i] = 0; m_col[i] = '0;
        end
        for (int k = 0; k < 3; k++)
            cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Single red crosshair
        set_marker(0, 5, 3, 1'b1, 24'hFF0000);
        set_marker(1, 5, 6, 1'b0, 24'h00FF00);
        run_frame(-1, -1, 0, 1'b0);
        // Overlapping markers: lower index wins at (5,6)
        set_marker(1, 5, 6, 1'b1, 24'h00FF00);
        run_frame(-1, -1, 0, 1'b0);
        // Box mode (crosshair when box logic is not compiled in)
        set_marker(0, 8, 4, 1'b1, 24'h0000FF);
        set_marker(1, 0, 0, 1'b0, 24'h00FF00);
        mode = 1'b1;
        run_frame(-1, -1, 0, 1'b0);
        mode = 1'b0;
        // Mid-frame x change takes effect only next frame
        set_marker(0, 5, 3, 1'b1, 24'hFF0000);
        run_frame(-1, 4, 9, 1'b0);
        run_frame(-1, -1, 0, 1'b0);
        // Off-image marker is suppressed
        set_marker(0, 20, 3, 1'b1, 24'hFF0000);
        run_frame(-1, -1, 0, 1'b0);
        // Mid-frame reset: no overlay until next frame start
        set_marker(0, 5, 3, 1'b1, 24'hFF0000);
        run_frame(-1, -1, 0, 1'b0);
        run_frame(2, -1, 0, 1'b0);
        run_frame(-1, -1, 0, 1'b0);
        // Randomized frames, including edges, off-image and de gaps
        for (int f = 0; f < 24; f++) begin
            for (int i = 0; i < NM; i++)
                set_marker(i, $urandom_range(0, 19), $urandom_range(0, 10),
                           1'($urandom), 24'($urandom));
            mode = 1'($urandom);
            run_frame(($urandom_range(0, 5) == 0) ? int'($urandom_range(0, H - 1)) : -1,
                      int'($urandom_range(0, H)), int'($urandom_range(0, 17)), 1'b1);
        end
        for (int k = 0; k < 4; k++)
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 20 && q.size() > 0; k++)
            @(posedge clk);
        #2;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/marker_overlay.md
MARKER_OVERLAY -- requirements
Module: marker_overlay

Interface
REQ-001 Parameter IMG_W, default 11'd1280: active pixels per line.
REQ-002 Parameter IMG_H, default 11'd720: active lines per frame.
REQ-003 Parameter N_MARK, default 2, legal 1..4: number of independent markers.
REQ-004 Parameter THICK, default 1, legal 1..8: line half-width. A pixel is on a line when |d| < THICK, so THICK=1 draws a single-pixel line.
REQ-005 Parameter BOX_HALF, default 16, legal THICK..255: half-size of the box-mode square.
REQ-006 Clock and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  pixel clock; all logic on its rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 de  in  1  data enable (active pixel).
REQ-010 h_sync  in  1  horizontal sync, passed through.
REQ-011 v_sync  in  1  vertical sync; high clears the position counters.
REQ-012 x  in  11*N_MARK  marker column coordinates; marker i occupies bits [11i+10:11i].
REQ-013 y  in  11*N_MARK  marker row coordinates, packed the same way as x.
REQ-014 mark_en  in  N_MARK  per-marker enable.
REQ-015 color  in  24*N_MARK  per-marker RGB colour, R in the MSB byte of each field.
REQ-016 mode  in  1  marker shape: 0 = crosshair, 1 = box.
REQ-017 pixel_in  in  24  input RGB pixel.
REQ-018 de_out, hsync_out, vsync_out  out  1 each  registered syncs.
REQ-019 pixel_out  out  24  registered output pixel.

Function
REQ-020 x_pos and y_pos SHALL be 11-bit counters cleared while v_sync=1. Otherwise, when de=1, x_pos increments. At x_pos=IMG_W-1 it wraps to 0 and y_pos increments. At y_pos=IMG_H-1 with an x wrap, y_pos wraps to 0.
REQ-021 On a v_sync rising edge (v_sync=1 while last-cycle v_sync=0), the block SHALL capture x, y, mark_en, color and mode into shadow registers. These shadows hold for the whole frame; input changes mid-frame have no effect.
REQ-022 A marker whose captured x >= IMG_W or y >= IMG_H SHALL be treated as disabled for that frame.
REQ-023 Crosshair hit for marker i: |x_pos-xs_i| < THICK or |y_pos-ys_i| < THICK. Use 12-bit signed differences; no wrap-around across image edges.
REQ-024 Box hit for marker i: |dx| <= BOX_HALF and |dy| <= BOX_HALF, and additionally |dx| > BOX_HALF-THICK or |dy| > BOX_HALF-THICK.
REQ-025 When several markers hit the same pixel, the lowest index SHALL win.
REQ-026 Latency SHALL be exactly 1 clk. de_out, hsync_out and vsync_out equal the inputs delayed 1 cycle.
REQ-027 pixel_out = colour of the winning marker when de=1 and a hit exists; otherwise pixel_in, delayed 1 cycle.
REQ-028 When de=0, no overlay is applied and the counters hold.

Reset
REQ-029 rst_n=0 SHALL immediately clear x_pos, y_pos, all shadows (mark_en shadow = 0), the last-cycle v_sync register and all outputs to 0.
REQ-030 After a mid-frame reset release, no marker is drawn until the next v_sync rising edge.

Configuration
REQ-031 Macro MARKER_OVERLAY_BOX_EN compiles in the box-mode logic of REQ-024.
REQ-032 Without MARKER_OVERLAY_BOX_EN, the mode input is ignored and always treated as 0 (crosshair); the port remains present.

Verification (bench: IMG_W=16, IMG_H=8, N_MARK=2, THICK=1, BOX_HALF=2)
REQ-033 Marker0 at (5,3), red 0xFF0000, mode 0, one full frame -> all of row 3 and column 5 are 0xFF0000 one clk after the matching input; all other pixels equal pixel_in.
REQ-034 Marker0 (5,3) red and marker1 (5,6) green 0x00FF00 -> pixel (5,6) is red (marker0 wins); the rest of row 6 is green.
REQ-035 Box mode (macro defined), marker0 at (8,4) -> border pixels with x in 6..10 and y in 2..6 are coloured, and interior pixel (8,4) = pixel_in. Macro undefined -> the same stimulus draws a crosshair.
REQ-036 x changed from 5 to 9 at row 4 mid-frame -> column 5 is drawn for the whole frame; column 9 appears only from the next frame.
REQ-037 Marker0 x=20 (>= IMG_W) -> no overlay for that frame; syncs still delayed 1 clk.
REQ-038 rst_n pulsed low at row 2 -> all outputs 0 while low; after release, pixel_out = pixel_in until the next v_sync rising edge.
